// File: rtl/mpu_writeback.sv
// Writeback stage feeding the register file: merges ALU results with FIFO-buffered
// load results into one registered write per cycle and tracks registers awaiting loads.
module mpu_writeback #(
  parameter int nb_reg     = 32,
  parameter int fifo_depth = 4,
  localparam int IW = nb_reg / 8 + 1,
  localparam int PW = $clog2(fifo_depth),
  localparam int LW = PW + 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              alu_valid,
  input  logic [IW-1:0]     alu_idx,
  input  logic [63:0]       alu_data,
  input  logic [2:0]        alu_sel,
  input  logic [1:0]        alu_size,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [IW-1:0]     ld_idx,
  input  logic [63:0]       ld_data,
  input  logic [2:0]        ld_sel,
  input  logic [1:0]        ld_size,
  input  logic              rsv_valid,
  input  logic [IW-1:0]     rsv_idx,
  output logic [nb_reg-1:0] busy,
  output logic [IW-1:0]     w_idx,
  output logic [63:0]       w_data,
  output logic [2:0]        w_sel,
  output logic [1:0]        w_size,
  output logic              we,
  output logic [LW-1:0]     fifo_level,
  output logic              err_waw
);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [63:0]   data;
    logic [2:0]    sel;
    logic [1:0]    size;
  } entry_t;

  localparam logic [LW-1:0] DEPTH = LW'(fifo_depth);

  entry_t            fifo_q [fifo_depth];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [nb_reg-1:0] busy_q, busy_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  entry_t            w_q, w_d;
  entry_t            head;
  logic              push, pop;

  // Indices beyond the register file are forwarded but never tracked.
  function automatic logic in_range(input logic [IW-1:0] i);
    return int'(i) < nb_reg;
  endfunction

  assign ld_ready = (level_q < DEPTH);

  always_comb begin
    push     = ld_valid && ld_ready;
    pop      = !alu_valid && (level_q != '0);
    head     = fifo_q[rd_ptr_q];
    we_d     = alu_valid || pop;
    w_d      = w_q;
    if (alu_valid) begin
      w_d = {alu_idx, alu_data, alu_sel, alu_size};
    end else if (pop) begin
      w_d = head;
    end
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A fresh reservation on the popping edge must survive the clear.
    busy_d = busy_q;
    if (pop && in_range(head.idx)) busy_d[head.idx] = 1'b0;
    if (rsv_valid && in_range(rsv_idx)) busy_d[rsv_idx] = 1'b1;
    err_d = err_q | (alu_valid && in_range(alu_idx) && busy_q[alu_idx]);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      w_q      <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      we_q     <= we_d;
      w_q      <= w_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) fifo_q[wr_ptr_q] <= {ld_idx, ld_data, ld_sel, ld_size};
  end

  assign we         = we_q;
  assign w_idx      = w_q.idx;
  assign w_data     = w_q.data;
  assign w_sel      = w_q.sel;
  assign w_size     = w_q.size;
  assign busy       = busy_q;
  assign fifo_level = level_q;
  assign err_waw    = err_q;

endmodule

// File: tb/tb_mpu_writeback.sv
// Bench for mpu_writeback: directed scenarios plus random traffic, scoreboarded
// against a queue-based reference model.
module tb_mpu_writeback;
  localparam int NB    = 32;
  localparam int DEPTH = 4;
  localparam int IW    = NB / 8 + 1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          alu_valid = 1'b0, ld_valid = 1'b0, rsv_valid = 1'b0;
  logic [IW-1:0] alu_idx = '0, ld_idx = '0, rsv_idx = '0;
  logic [63:0]   alu_data = '0, ld_data = '0;
  logic [2:0]    alu_sel = '0, ld_sel = '0;
  logic [1:0]    alu_size = '0, ld_size = '0;
  logic          ld_ready, we, err_waw;
  logic [NB-1:0] busy;
  logic [IW-1:0] w_idx;
  logic [63:0]   w_data;
  logic [2:0]    w_sel;
  logic [1:0]    w_size;
  logic [LW-1:0] fifo_level;

  mpu_writeback #(.nb_reg(NB), .fifo_depth(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_data(alu_data),
    .alu_sel(alu_sel), .alu_size(alu_size),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_idx(ld_idx), .ld_data(ld_data),
    .ld_sel(ld_sel), .ld_size(ld_size),
    .rsv_valid(rsv_valid), .rsv_idx(rsv_idx), .busy(busy),
    .w_idx(w_idx), .w_data(w_data), .w_sel(w_sel), .w_size(w_size), .we(we),
    .fifo_level(fifo_level), .err_waw(err_waw)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic [63:0]   data;
    logic [2:0]    sel;
    logic [1:0]    size;
  } wr_t;

  wr_t           ldq[$];
  wr_t           expq[$];
  wr_t           m_last;
  logic          m_we;
  logic [NB-1:0] m_busy;
  logic          m_err;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    ldq.delete();
    expq.delete();
    m_last = '{idx: '0, data: '0, sel: '0, size: '0};
    m_we   = 1'b0;
    m_busy = '0;
    m_err  = 1'b0;
  endfunction

  // Reference behaviour for one rising edge, from the inputs currently applied.
  function automatic void model_edge();
    bit  can_take;
    wr_t e;
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    can_take = ldq.size() < DEPTH;
    m_we = 1'b0;
    if (alu_valid) begin
      if (int'(alu_idx) < NB && m_busy[alu_idx]) m_err = 1'b1;
      e = '{idx: alu_idx, data: alu_data, sel: alu_sel, size: alu_size};
      expq.push_back(e);
      m_last = e;
      m_we = 1'b1;
    end else if (ldq.size() > 0) begin
      e = ldq.pop_front();
      expq.push_back(e);
      m_last = e;
      m_we = 1'b1;
      if (int'(e.idx) < NB) m_busy[e.idx] = 1'b0;
    end
    if (ld_valid && can_take)
      ldq.push_back('{idx: ld_idx, data: ld_data, sel: ld_sel, size: ld_size});
    if (rsv_valid && int'(rsv_idx) < NB) m_busy[rsv_idx] = 1'b1;
  endfunction

  // Monitor: sampled on the falling edge, pops the scoreboard on every write.
  initial begin
    wr_t e;
    forever begin
      @(negedge sys_clk);
      chk("we", 64'(we), 64'(m_we));
      if (we) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", 64'(we), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("w_idx", 64'(w_idx), 64'(e.idx));
          chk("w_data", w_data, e.data);
          chk("w_sel", 64'(w_sel), 64'(e.sel));
          chk("w_size", 64'(w_size), 64'(e.size));
        end
      end else begin
        if (m_we && expq.size() > 0) void'(expq.pop_front());
        chk("w_idx_hold", 64'(w_idx), 64'(m_last.idx));
        chk("w_data_hold", w_data, m_last.data);
      end
      chk("fifo_level", 64'(fifo_level), 64'(ldq.size()));
      chk("ld_ready", 64'(ld_ready), 64'(ldq.size() < DEPTH));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("err_waw", 64'(err_waw), 64'(m_err));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    rsv_valid = 1'b0;
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    #1;
    model_edge();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    idle();
    cycle();
    cycle();
    sys_rst_n = 1'b1;
  endtask

  task automatic set_alu(input logic [IW-1:0] i, input logic [63:0] d,
                         input logic [2:0] s, input logic [1:0] z);
    alu_valid = 1'b1; alu_idx = i; alu_data = d; alu_sel = s; alu_size = z;
  endtask

  task automatic set_ld(input logic [IW-1:0] i, input logic [63:0] d,
                        input logic [2:0] s, input logic [1:0] z);
    ld_valid = 1'b1; ld_idx = i; ld_data = d; ld_sel = s; ld_size = z;
  endtask

  initial begin
    model_reset();
    // Reset held with ALU traffic present
    sys_rst_n = 1'b0;
    set_alu(5'd1, 64'hDEAD, 3'd0, 2'd3);
    repeat (3) cycle();
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(ld_ready), 64'(1));
    chk("rst_level", 64'(fifo_level), 64'(0));
    idle();
    sys_rst_n = 1'b1;
    cycle();
    chk("rst_release_we", 64'(we), 64'(0));

    // ALU write
    set_alu(5'd5, 64'h1122334455667788, 3'd2, 2'd1);
    cycle();
    idle();
    chk("alu_we", 64'(we), 64'(1));
    chk("alu_idx", 64'(w_idx), 64'(5));
    chk("alu_data", w_data, 64'h1122334455667788);
    chk("alu_sel", 64'(w_sel), 64'(2));
    chk("alu_size", 64'(w_size), 64'(1));
    cycle();
    chk("alu_we_drop", 64'(we), 64'(0));

    // Reserve, then load returns and clears
    rsv_valid = 1'b1; rsv_idx = 5'd7;
    cycle();
    idle();
    chk("rsv_busy7", 64'(busy[7]), 64'(1));
    cycle();
    set_ld(5'd7, 64'hCAFE, 3'd0, 2'd3);
    cycle();
    idle();
    chk("ld_not_yet", 64'(we), 64'(0));
    cycle();
    chk("ld_we", 64'(we), 64'(1));
    chk("ld_idx", 64'(w_idx), 64'(7));
    chk("ld_data", w_data, 64'hCAFE);
    chk("ld_busy7_clr", 64'(busy[7]), 64'(0));

    // ALU priority fills the FIFO; loads drain in order afterwards
    for (int i = 0; i < 8; i++) begin
      set_alu(IW'(i), {$urandom, $urandom}, 3'(i), 2'(i));
      if (i < 5) set_ld(IW'(10 + i), 64'(100 + i), 3'd1, 2'd2);
      else ld_valid = 1'b0;
      cycle();
    end
    idle();
    chk("full_level", 64'(fifo_level), 64'(4));
    chk("full_ready", 64'(ld_ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("drain_we", 64'(we), 64'(1));
      chk("drain_idx", 64'(w_idx), 64'(10 + k));
    end
    cycle();
    chk("drain_done_we", 64'(we), 64'(0));
    chk("drain_level", 64'(fifo_level), 64'(0));

    // Reservation on the same edge as the pop keeps the register busy
    rsv_valid = 1'b1; rsv_idx = 5'd7;
    cycle();
    idle();
    set_ld(5'd7, 64'hBEEF, 3'd4, 2'd0);
    cycle();
    idle();
    rsv_valid = 1'b1; rsv_idx = 5'd7;
    cycle();
    idle();
    chk("setwins_we", 64'(we), 64'(1));
    chk("setwins_idx", 64'(w_idx), 64'(7));
    chk("setwins_busy7", 64'(busy[7]), 64'(1));

    // ALU write to a pending register flags the hazard
    chk("waw_clear_before", 64'(err_waw), 64'(0));
    rsv_valid = 1'b1; rsv_idx = 5'd3;
    cycle();
    idle();
    set_alu(5'd3, 64'h3333, 3'd0, 2'd2);
    cycle();
    idle();
    chk("waw_we", 64'(we), 64'(1));
    chk("waw_idx", 64'(w_idx), 64'(3));
    chk("waw_err", 64'(err_waw), 64'(1));
    repeat (3) cycle();
    chk("waw_sticky", 64'(err_waw), 64'(1));
    do_reset();
    chk("waw_reset", 64'(err_waw), 64'(0));
    chk("busy_reset", 64'(busy), 64'(0));

    // Random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        set_ld(5'd9, 64'h99, 3'd0, 2'd0);
        cycle();
        do_reset();
      end
      alu_valid = ($urandom_range(0, 99) < 35);
      alu_idx   = IW'($urandom_range(0, NB - 1));
      alu_data  = {$urandom, $urandom};
      alu_sel   = 3'($urandom);
      alu_size  = 2'($urandom);
      ld_valid  = ($urandom_range(0, 99) < 50);
      ld_idx    = IW'($urandom_range(0, NB - 1));
      ld_data   = {$urandom, $urandom};
      ld_sel    = 3'($urandom);
      ld_size   = 2'($urandom);
      rsv_valid = ($urandom_range(0, 99) < 30);
      rsv_idx   = IW'($urandom_range(0, NB - 1));
      cycle();
    end
    idle();
    repeat (8) cycle();
    chk("final_level", 64'(fifo_level), 64'(0));
    @(negedge sys_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
